// File: rtl/tx_framer_if.sv
// -----------------------------------------------------------------------------
// tx_framer_if
//
// Write-side handshake between the CPU (producer) and the tx_framer FIFO.
//
// Signals:
//   wr_valid  producer -> framer  write request
//   wr_data   producer -> framer  7-bit character to queue
//   wr_last   producer -> framer  with wr_valid: character ends the message
//   wr_ready  framer -> producer  FIFO can accept a write this cycle
//
// Modports:
//   master  producer side (drives valid/data/last, samples ready)
//   slave   framer side   (samples valid/data/last, drives ready)
// -----------------------------------------------------------------------------
interface tx_framer_if;
    logic       wr_valid;
    logic [6:0] wr_data;
    logic       wr_last;
    logic       wr_ready;

    modport master (
        output wr_valid,
        output wr_data,
        output wr_last,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        input  wr_last,
        output wr_ready
    );
endinterface

// File: rtl/tx_framer.sv
// -----------------------------------------------------------------------------
// tx_framer
//
// Transmit side of the 7-bit framed character stream. The CPU queues
// characters into an internal FIFO, flagging the final character of each
// message. A frame (00, chars..., 7F) is emitted only once a complete message
// is buffered, so a frame never stalls mid-way: the receiver takes one
// character per clock. 7F doubles as the line-idle value.
//
// Parameters:
//   DEPTH  FIFO entries (power of two, >= 2); also the maximum message length
//   CNT_W  width of the pending-message counter; must be able to hold DEPTH
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-low reset
//   wr         write handshake (tx_framer_if.slave)
//   tx         framed character stream, registered
//   busy       frame in progress (START/DATA/STOP), registered
//   bad_char   sticky: a write of 0x00 or 0x7F was dropped
//   overflow   sticky: a full FIFO holding no complete message was flushed
//   err_clr    clears bad_char and overflow (a same-cycle set wins)
//   frame_cnt  [TX_FRAMER_STATS_EN only] frames completed, wrapping
//   drop_cnt   [TX_FRAMER_STATS_EN only] dropped chars + flushes, saturating
//
// Optional feature macro: TX_FRAMER_STATS_EN (adds frame_cnt / drop_cnt).
// -----------------------------------------------------------------------------
module tx_framer #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic        clk,
    input  logic        reset,
    tx_framer_if.slave  wr,
    output logic [6:0]  tx,
    output logic        busy,
    output logic        bad_char,
    output logic        overflow,
`ifdef TX_FRAMER_STATS_EN
    output logic [15:0] frame_cnt,
    output logic [15:0] drop_cnt,
`endif
    input  logic        err_clr
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [6:0] CH_OPEN  = 7'h00;
    localparam logic [6:0] CH_CLOSE = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // FIFO storage: {last, char}
    logic [7:0]       mem [DEPTH];

    // One extra pointer bit distinguishes full from empty; wrap is natural.
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [CNT_W-1:0] msg_cnt_reg;
    state_t           state_reg;
    // last flag of the character currently on tx while in DATA
    logic             last_popped_reg;

    logic             full;
    logic             illegal;
    logic             push;
    logic             flush;
    logic             pop;
    logic             pop_last;
    logic             cnt_inc;
    logic [7:0]       head;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    assign full = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    assign wr.wr_ready = !full;

    // Framing characters cannot be carried as payload; they are dropped
    // (together with any last flag they carry).
    assign illegal = wr.wr_valid &&
                     ((wr.wr_data == CH_OPEN) || (wr.wr_data == CH_CLOSE));

    assign push    = wr.wr_valid && !full && !illegal;
    assign cnt_inc = push && wr.wr_last;

    // A full FIFO with no complete message can never drain: the partial
    // message is longer than the FIFO. Throw it away.
    assign flush = full && (msg_cnt_reg == '0);

    // ------------------------------------------------------------------
    // Read side: a pop happens on the edge entering DATA and on every DATA
    // edge until the character on tx was the message's last one.
    // ------------------------------------------------------------------
    assign head     = mem[rd_ptr_reg[AW-1:0]];
    assign pop      = (state_reg == START) ||
                      ((state_reg == DATA) && !last_popped_reg);
    assign pop_last = pop && head[7];

    // Storage has no reset so it can map onto RAM resources.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= {wr.wr_last, wr.wr_data};
        end
    end

    // ------------------------------------------------------------------
    // Pointers, message count, sticky flags and the framing FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            msg_cnt_reg     <= '0;
            state_reg       <= IDLE;
            last_popped_reg <= 1'b0;
            tx              <= CH_CLOSE;
            busy            <= 1'b0;
            bad_char        <= 1'b0;
            overflow        <= 1'b0;
        end else begin
            // flush and pop never coincide: a pop requires a buffered
            // complete message, a flush requires none.
            if (flush) begin
                wr_ptr_reg <= rd_ptr_reg;
            end else if (push) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end

            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end

            case ({cnt_inc, pop_last})
                2'b10:   msg_cnt_reg <= msg_cnt_reg + CNT_W'(1);
                2'b01:   msg_cnt_reg <= msg_cnt_reg - CNT_W'(1);
                default: msg_cnt_reg <= msg_cnt_reg;
            endcase

            if (illegal) begin
                bad_char <= 1'b1;
            end else if (err_clr) begin
                bad_char <= 1'b0;
            end

            if (flush) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end

            // tx and busy are loaded with the value of the state being entered.
            case (state_reg)
                IDLE: begin
                    if (msg_cnt_reg != '0) begin
                        state_reg <= START;
                        tx        <= CH_OPEN;
                        busy      <= 1'b1;
                    end else begin
                        tx   <= CH_CLOSE;
                        busy <= 1'b0;
                    end
                end
                START: begin
                    state_reg       <= DATA;
                    tx              <= head[6:0];
                    last_popped_reg <= head[7];
                    busy            <= 1'b1;
                end
                DATA: begin
                    busy <= 1'b1;
                    if (last_popped_reg) begin
                        state_reg <= STOP;
                        tx        <= CH_CLOSE;
                    end else begin
                        tx              <= head[6:0];
                        last_popped_reg <= head[7];
                    end
                end
                STOP: begin
                    // The just-finished message was already subtracted when
                    // its last character was popped.
                    if (msg_cnt_reg != '0) begin
                        state_reg <= START;
                        tx        <= CH_OPEN;
                        busy      <= 1'b1;
                    end else begin
                        state_reg <= IDLE;
                        tx        <= CH_CLOSE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    tx        <= CH_CLOSE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef TX_FRAMER_STATS_EN
    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    logic [1:0]  drop_inc;
    logic [16:0] drop_sum;

    // An illegal write and a flush may land in the same cycle: count both.
    assign drop_inc = {1'b0, illegal} + {1'b0, flush};
    assign drop_sum = {1'b0, drop_cnt} + 17'(drop_inc);

    always_ff @(posedge clk) begin
        if (!reset) begin
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if ((state_reg == DATA) && last_popped_reg) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_tx_framer.sv
// -----------------------------------------------------------------------------
// tb_tx_framer
//
// Directed bench for tx_framer. A queue-based model of the line (FIFO contents,
// complete-message count, and a schedule of symbols still to be put on tx) is
// compared with the DUT every cycle; each scenario additionally pins the tx
// stream and flags against hand-written literal sequences.
// -----------------------------------------------------------------------------
module tb_tx_framer;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;
    localparam int LOGN  = 1024;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       err_clr = 1'b0;
    logic [6:0] tx;
    logic       busy;
    logic       bad_char;
    logic       overflow;
`ifdef TX_FRAMER_STATS_EN
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;
`endif

    tx_framer_if wif ();

    tx_framer #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr        (wif.slave),
        .tx        (tx),
        .busy      (busy),
        .bad_char  (bad_char),
        .overflow  (overflow),
`ifdef TX_FRAMER_STATS_EN
        .frame_cnt (frame_cnt),
        .drop_cnt  (drop_cnt),
`endif
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: FIFO as a queue of {last,char}; sched holds symbols that still
    // have to appear on tx (0=open, 1=next FIFO char, 2=close).
    // ------------------------------------------------------------------
    logic [7:0] mq[$];
    int         sched[$];
    int         m_msgs;
    logic [6:0] m_tx;
    logic       m_busy;
    logic       m_bad;
    logic       m_ovf;
    int         m_frames;
    int         m_drops;

    logic       t_full;
    logic       t_illegal;
    logic       t_flush;
    int         t_pre_msgs;
    int         t_tok;
    int         t_k;
    logic [7:0] t_e;

    // Per-cycle log of DUT outputs for the literal checks.
    logic [6:0] txlog  [LOGN];
    logic       busylog[LOGN];
    logic       badlog [LOGN];
    logic       ovflog [LOGN];
    logic       rdylog [LOGN];
    int         ncyc = 0;

    always @(posedge clk) begin
        if (!reset) begin
            mq.delete();
            sched.delete();
            m_msgs   = 0;
            m_tx     = 7'h7F;
            m_busy   = 1'b0;
            m_bad    = 1'b0;
            m_ovf    = 1'b0;
            m_frames = 0;
            m_drops  = 0;
        end else begin
            t_full     = (mq.size() == DEPTH);
            t_pre_msgs = m_msgs;
            t_illegal  = wif.wr_valid &&
                         ((wif.wr_data == 7'h00) || (wif.wr_data == 7'h7F));
            t_flush    = t_full && (t_pre_msgs == 0);

            // line free and a whole message waiting: lay out its frame
            if ((sched.size() == 0) && (t_pre_msgs > 0)) begin
                sched.push_back(0);
                t_k = 0;
                while ((t_k < mq.size()) && !mq[t_k][7]) begin
                    sched.push_back(1);
                    t_k++;
                end
                sched.push_back(1);
                sched.push_back(2);
            end

            if (sched.size() > 0) begin
                t_tok  = sched.pop_front();
                m_busy = 1'b1;
                case (t_tok)
                    0: m_tx = 7'h00;
                    1: begin
                        t_e  = mq.pop_front();
                        m_tx = t_e[6:0];
                        if (t_e[7]) m_msgs--;
                    end
                    default: begin
                        m_tx = 7'h7F;
                        m_frames++;
                    end
                endcase
            end else begin
                m_busy = 1'b0;
                m_tx   = 7'h7F;
            end

            if (t_flush) begin
                mq.delete();
            end else if (wif.wr_valid && !t_full && !t_illegal) begin
                mq.push_back({wif.wr_last, wif.wr_data});
                if (wif.wr_last) m_msgs++;
            end

            m_drops = m_drops + int'(t_illegal) + int'(t_flush);
            if (m_drops > 65535) m_drops = 65535;

            if (t_illegal)    m_bad = 1'b1;
            else if (err_clr) m_bad = 1'b0;
            if (t_flush)      m_ovf = 1'b1;
            else if (err_clr) m_ovf = 1'b0;
        end

        #2;
        check("tx", tx, m_tx);
        check("busy", busy, m_busy);
        check("wr_ready", wif.wr_ready, (mq.size() != DEPTH));
        check("bad_char", bad_char, m_bad);
        check("overflow", overflow, m_ovf);
`ifdef TX_FRAMER_STATS_EN
        check("frame_cnt", frame_cnt, m_frames % 65536);
        check("drop_cnt", drop_cnt, m_drops);
`endif
        if (ncyc < LOGN) begin
            txlog[ncyc]   = tx;
            busylog[ncyc] = busy;
            badlog[ncyc]  = bad_char;
            ovflog[ncyc]  = overflow;
            rdylog[ncyc]  = wif.wr_ready;
        end
        ncyc++;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change on the falling edge
    // ------------------------------------------------------------------
    task automatic drive(input logic v, input logic [6:0] d, input logic l,
                         input logic c, input logic r);
        @(negedge clk);
        wif.wr_valid = v;
        wif.wr_data  = d;
        wif.wr_last  = l;
        err_clr      = c;
        reset        = r;
    endtask

    task automatic wr(input logic [6:0] d, input logic l);
        drive(1'b1, d, l, 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 7'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic check_tx_seq(input string name, input int s,
                                input logic [6:0] exp [], input int n);
        for (int i = 0; i < n; i++)
            check($sformatf("%s tx[%0d]", name, i), txlog[s+i], exp[i]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int s;
    int t;
    int nb;
    logic [6:0] e1 [];
    logic [6:0] e2 [];
    logic [6:0] e3 [];
    logic [6:0] e6 [];

    initial begin
        wif.wr_valid = 1'b0;
        wif.wr_data  = 7'h00;
        wif.wr_last  = 1'b0;
        reset        = 1'b0;
        drive(1'b0, 7'h00, 1'b0, 1'b0, 1'b0);
        s = ncyc;
        idle(2);
        // reset state
        check("rst tx", txlog[s], 7'h7F);
        check("rst busy", busylog[s], 0);
        check("rst ready", rdylog[s], 1);

        // 1: "Hi" -> 7F 7F 00 48 69 7F 7F, busy for 4 cycles
        e1 = '{7'h7F, 7'h7F, 7'h00, 7'h48, 7'h69, 7'h7F, 7'h7F};
        wr(7'h48, 1'b0);
        s = ncyc;
        wr(7'h69, 1'b1);
        idle(8);
        check_tx_seq("hi", s, e1, 7);
        nb = 0;
        for (int i = 0; i < 8; i++) nb += int'(busylog[s+i]);
        check("hi busy cycles", nb, 4);

        // 2: two one-char messages back to back, single 7F between frames
        e2 = '{7'h7F, 7'h00, 7'h41, 7'h7F, 7'h00, 7'h42, 7'h7F, 7'h7F};
        wr(7'h41, 1'b1);
        s = ncyc;
        wr(7'h42, 1'b1);
        idle(8);
        check_tx_seq("ab", s, e2, 8);

        // 3: illegal characters dropped, their last flag lost
        e3 = '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h00, 7'h41, 7'h42, 7'h7F};
        wr(7'h41, 1'b0);
        s = ncyc;
        wr(7'h00, 1'b0);
        wr(7'h7F, 1'b1);
        wr(7'h42, 1'b1);
        idle(6);
        check_tx_seq("bad", s, e3, 8);
        check("bad before", badlog[s], 0);
        check("bad set", badlog[s+1], 1);
        drive(1'b0, 7'h00, 1'b0, 1'b1, 1'b1);
        t = ncyc;
        idle(2);
        check("bad held", badlog[t-1], 1);
        check("bad cleared", badlog[t], 0);

        // 4: DEPTH chars with no last -> full, flush, overflow
        for (int i = 0; i < DEPTH; i++) begin
            wr(7'(8'h31 + i), 1'b0);
            if (i == 0) s = ncyc;
        end
        wr(7'h39, 1'b1);                 // rejected: the flush cycle
        wr(7'h35, 1'b1);
        idle(5);
        check("ovf ready low", rdylog[s+DEPTH-1], 0);
        check("ovf before", ovflog[s+DEPTH-1], 0);
        check("ovf set", ovflog[s+DEPTH], 1);
        check("ovf ready back", rdylog[s+DEPTH], 1);
        for (int i = 0; i <= DEPTH + 1; i++)
            check($sformatf("ovf idle tx[%0d]", i), txlog[s+i], 7'h7F);
        check("ovf f0", txlog[s+DEPTH+2], 7'h00);
        check("ovf f1", txlog[s+DEPTH+3], 7'h35);
        check("ovf f2", txlog[s+DEPTH+4], 7'h7F);

        // 5: reset in the middle of a 5-char frame
        for (int i = 0; i < 5; i++) begin
            wr(7'(8'h61 + i), (i == 4));
            if (i == 0) s = ncyc;
        end
        idle(3);
        drive(1'b0, 7'h00, 1'b0, 1'b0, 1'b0);
        idle(8);
        check("rstmid pre", txlog[s+7], 7'h62);
        check("rstmid tx", txlog[s+8], 7'h7F);
        check("rstmid busy", busylog[s+8], 0);
        check("rstmid ovf", ovflog[s+8], 0);
        nb = 0;
        for (int i = 9; i < 16; i++) nb += int'(busylog[s+i]);
        check("rstmid no frame", nb, 0);

        // 6: new message's last written as the current last is popped
        e6 = '{7'h7F, 7'h00, 7'h50, 7'h7F, 7'h00, 7'h51, 7'h7F};
        wr(7'h50, 1'b1);
        s = ncyc;
        idle(1);
        wr(7'h51, 1'b1);
        idle(6);
        check_tx_seq("sim", s, e6, 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
